// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into press / long-press events on a valid/ready port.
// Define BTN_AUTOREPEAT_EN to get periodic repeat events while a button stays held.
module button_event_ctrl #(
  parameter int unsigned N_BTN        = 3,
  parameter int unsigned TICK_DIV     = 100000,
  parameter int unsigned HOLD_TICKS   = 500,
  parameter int unsigned REPEAT_TICKS = 100
) (
  input  logic                                       clk_in,
  input  logic                                       rst_n_in,
  input  logic [N_BTN-1:0]                           btn_in,
  output logic                                       tick_out,
  output logic                                       event_valid_out,
  input  logic                                       event_ready_in,
  output logic [$clog2(N_BTN > 1 ? N_BTN : 2)-1:0]   event_id_out,
  output logic                                       event_long_out,
  output logic                                       busy_out,
  output logic                                       overrun_out
);

  localparam int unsigned IdW = $clog2(N_BTN > 1 ? N_BTN : 2);
  localparam int unsigned TickW = $clog2(TICK_DIV > 1 ? TICK_DIV : 2);
  localparam int unsigned HoldW = $clog2(HOLD_TICKS + 1);
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_TICKS - 1);

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_TICKS + 1);
  localparam logic [RepW-1:0] RepLast = RepW'(REPEAT_TICKS - 1);
  typedef enum logic [1:0] {StIdle, StHeld, StRepeat} state_e;
  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
`else
  typedef enum logic [1:0] {StIdle, StHeld, StLong} state_e;
`endif

  state_e             state_q, state_d;
  logic [TickW-1:0]   tick_cnt_q;
  logic [N_BTN-1:0]   btn_q;
  logic [N_BTN-1:0]   rise;
  logic [IdW-1:0]     first_rise;
  logic [IdW-1:0]     lock_id_q, lock_id_d;
  logic [HoldW-1:0]   hold_cnt_q, hold_cnt_d;
  logic               emit, emit_long;
  logic               valid_q, valid_d;
  logic [IdW-1:0]     ev_id_q, ev_id_d;
  logic               ev_long_q, ev_long_d;
  logic               overrun_q, overrun_d;

  // Free-running sample tick; the FSM never realigns it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tick_cnt_q <= '0;
    end else if (tick_cnt_q == TickLast) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TickW'(1);
    end
  end

  assign tick_out = (tick_cnt_q == TickLast);
  assign rise     = btn_in & ~btn_q;

  always_comb begin
    first_rise = '0;
    for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
      if (rise[i]) first_rise = IdW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_id_d  = lock_id_q;
    hold_cnt_d = hold_cnt_q;
`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_d  = rep_cnt_q;
`endif
    emit       = 1'b0;
    emit_long  = 1'b0;
    case (state_q)
      StIdle: begin
        if (|rise) begin
          lock_id_d  = first_rise;
          hold_cnt_d = '0;
          emit       = 1'b1;
          state_d    = StHeld;
        end
      end
      StHeld: begin
        // Release wins over a coincident tick.
        if (!btn_in[lock_id_q]) begin
          state_d = StIdle;
        end else if (tick_out) begin
          if (hold_cnt_q == HoldLast) begin
            emit      = 1'b1;
            emit_long = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt_d = '0;
            state_d   = StRepeat;
`else
            state_d   = StLong;
`endif
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
      end
`ifdef BTN_AUTOREPEAT_EN
      StRepeat: begin
        if (!btn_in[lock_id_q]) begin
          state_d = StIdle;
        end else if (tick_out) begin
          if (rep_cnt_q == RepLast) begin
            emit      = 1'b1;
            emit_long = 1'b1;
            rep_cnt_d = '0;
          end else begin
            rep_cnt_d = rep_cnt_q + RepW'(1);
          end
        end
      end
`else
      StLong: begin
        if (!btn_in[lock_id_q]) state_d = StIdle;
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // A new event never overwrites one the consumer has not taken yet.
  always_comb begin
    valid_d   = valid_q;
    ev_id_d   = ev_id_q;
    ev_long_d = ev_long_q;
    overrun_d = overrun_q;
    if (emit && valid_q && !event_ready_in) begin
      overrun_d = 1'b1;
    end else if (emit) begin
      valid_d   = 1'b1;
      ev_id_d   = lock_id_d;
      ev_long_d = emit_long;
    end else if (valid_q && event_ready_in) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= StIdle;
      btn_q      <= '0;
      lock_id_q  <= '0;
      hold_cnt_q <= '0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q  <= '0;
`endif
      valid_q    <= 1'b0;
      ev_id_q    <= '0;
      ev_long_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn_in;
      lock_id_q  <= lock_id_d;
      hold_cnt_q <= hold_cnt_d;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_q  <= rep_cnt_d;
`endif
      valid_q    <= valid_d;
      ev_id_q    <= ev_id_d;
      ev_long_q  <= ev_long_d;
      overrun_q  <= overrun_d;
    end
  end

  assign event_valid_out = valid_q;
  assign event_id_out    = ev_id_q;
  assign event_long_out  = ev_long_q;
  assign overrun_out     = overrun_q;
  assign busy_out        = (state_q != StIdle);

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scoreboard bench for button_event_ctrl: expected events are queued as buttons are driven.
module tb_button_event_ctrl;

  localparam int TickDiv = 4;
  localparam int Hold    = 3;
  localparam int Rep     = 2;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] btn = 3'b000;
  logic       ready = 1'b1;
  logic       tick, valid, lng, busy, ovr;
  logic [1:0] id;

  button_event_ctrl #(
    .N_BTN       (3),
    .TICK_DIV    (TickDiv),
    .HOLD_TICKS  (Hold),
    .REPEAT_TICKS(Rep)
  ) dut (
    .clk_in         (clk),
    .rst_n_in       (rst_n),
    .btn_in         (btn),
    .tick_out       (tick),
    .event_valid_out(valid),
    .event_ready_in (ready),
    .event_id_out   (id),
    .event_long_out (lng),
    .busy_out       (busy),
    .overrun_out    (ovr)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release; the DUT tick fires in cycles where cyc % 4 == 3.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  typedef struct {
    int id;
    int lng;
    int at;
  } ev_t;
  ev_t sb[$];

  task automatic push_ev(input int eid, input int elong, input int at);
    ev_t e;
    e.id = eid;
    e.lng = elong;
    e.at = at;
    sb.push_back(e);
  endtask

  // Button eid pressed in cycle n, released in cycle r (ready held high).
  task automatic push_hold(input int eid, input int n, input int r);
    int k = 0;
    push_ev(eid, 0, n + 1);
    for (int m = n + 1; m < r; m++) begin
      if (m % TickDiv == TickDiv - 1) begin
        k++;
        if (k == Hold) push_ev(eid, 1, m + 1);
        else if (Auto && k > Hold && (k - Hold) % Rep == 0) push_ev(eid, 1, m + 1);
      end
    end
  endtask

  int busy_cnt = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (busy) busy_cnt++;
      if (valid && ready) begin
        check("sb_avail", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          ev_t e;
          e = sb.pop_front();
          check("ev_id", 32'(id), e.id);
          check("ev_long", 32'(lng), e.lng);
          if (e.at >= 0) check("ev_cycle", cyc, e.at);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  int n, r, k;

  initial begin
    // Reset with all buttons pressed
    rst_n = 1'b0;
    btn   = 3'b111;
    ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rst_outs", 32'({tick, valid, id, lng, busy, ovr}), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    btn   = 3'b000;
    repeat (8) begin
      @(negedge clk);
      check("tick_phase", 32'(tick), 32'(cyc % TickDiv == TickDiv - 1));
      check("idle_quiet", 32'({valid, busy}), 0);
    end

    // Short press of button 1
    @(negedge clk);
    busy_cnt = 0;
    n = cyc;
    btn = 3'b010;
    push_hold(1, n, n + 5);
    repeat (5) @(negedge clk);
    btn = 3'b000;
    repeat (6) @(negedge clk);
    check("short_busy", busy_cnt, 5);
    check("short_drain", sb.size(), 0);

    // Long press of button 0
    @(negedge clk);
    n = cyc;
    btn = 3'b001;
    push_hold(0, n, n + 40);
    repeat (39) @(negedge clk);
    check("long_busy", 32'(busy), 1);
    @(negedge clk);
    btn = 3'b000;
    repeat (3) @(negedge clk);
    check("long_idle", 32'(busy), 0);
    repeat (8) @(negedge clk);
    check("long_drain", sb.size(), 0);

    // Simultaneous press, locked-out pulses, release on the would-be long tick
    @(negedge clk);
    n = cyc;
    btn = 3'b110;
    k = 0;
    r = 0;
    for (int m = n + 1; r == 0; m++) begin
      if (m % TickDiv == TickDiv - 1) begin
        k++;
        if (k == Hold) r = m;
      end
    end
    push_hold(1, n, r);
    @(negedge clk) btn = 3'b010;
    @(negedge clk) btn = 3'b110;
    @(negedge clk) btn = 3'b010;
    @(negedge clk) btn = 3'b110;
    while (cyc < r) @(negedge clk);
    check("rel_on_tick", 32'(tick), 1);
    btn = 3'b100;
    repeat (6) @(negedge clk);
    check("locked_idle", 32'(busy), 0);
    btn = 3'b000;
    repeat (4) @(negedge clk);
    check("locked_drain", sb.size(), 0);

    // Backpressure: first event held, later ones dropped
    @(negedge clk);
    ready = 1'b0;
    btn = 3'b001;
    push_ev(0, 0, -1);
    repeat (20) @(negedge clk);
    check("bp_valid", 32'(valid), 1);
    check("bp_id", 32'(id), 0);
    check("bp_long", 32'(lng), 0);
    check("bp_ovr", 32'(ovr), 1);
    btn = 3'b000;
    repeat (3) @(negedge clk);
    check("bp_still_pending", 32'({valid, lng}), 32'b10);
    ready = 1'b1;
    repeat (4) @(negedge clk);
    check("bp_drain", sb.size(), 0);
    check("bp_valid_off", 32'(valid), 0);
    check("bp_ovr_sticky", 32'(ovr), 1);

    rst_n = 1'b0;
    #1;
    check("rst_clears_ovr", 32'(ovr), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/button_event_ctrl.md
Name: button_event_ctrl

Overview:
- Sequences the debounced push-button levels of the egg timer (start/stop, minute-up, second-up) into discrete press events for the timer core.
- Generates the slow sample tick and arbitrates between buttons, locking onto one button at a time.
- Produces short-press, long-press and optional auto-repeat events over a valid/ready handshake.
- Sits between the per-button debouncers and the timer control FSM.

Parameters:
- N_BTN, 3, number of debounced button inputs.
- TICK_DIV, 100000, clk_in cycles per sample tick (1 ms at 100 MHz).
- HOLD_TICKS, 500, ticks a button must stay held before the long-press event.
- REPEAT_TICKS, 100, ticks between auto-repeat events while held.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  asynchronous active-low reset.
- btn_in  input  N_BTN  debounced button levels, active high, synchronous to clk_in.
- tick_out  output  1  one-cycle strobe every TICK_DIV cycles.
- event_valid_out  output  1  event pending.
- event_ready_in  input  1  consumer accepts the event when high together with valid.
- event_id_out  output  max(1,$clog2(N_BTN))  index of the button that caused the event.
- event_long_out  output  1  0 = initial press, 1 = long-press or repeat event.
- busy_out  output  1  high while a button is locked (FSM not IDLE).
- overrun_out  output  1  sticky: an event was dropped because the previous one was unaccepted.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM IDLE, all counters 0, btn_q = 0.
- Tick counter: free-running 0..TICK_DIV-1, never cleared by the FSM. tick_out = 1 in the cycle where count == TICK_DIV-1.
- Edge detect: btn_q <= btn_in each cycle; rise = btn_in & ~btn_q.
- FSM states: IDLE, HELD, REPEAT (REPEAT only with the macro; LONG without it).
- IDLE:
  - if rise != 0, lock id = lowest set index of rise;
  - emit event (long = 0);
  - hold_cnt <= 0; go HELD.
  - Other simultaneous rises are discarded.
- HELD:
  - if btn_in[id] == 0, go IDLE (release has priority over a coincident tick).
  - else on tick_out, hold_cnt++. When hold_cnt == HOLD_TICKS-1 on a tick, emit event (long = 1), rep_cnt <= 0, go REPEAT.
- REPEAT:
  - release goes IDLE.
  - else on tick, rep_cnt++. At REPEAT_TICKS-1, emit event (long = 1), rep_cnt <= 0.
- While the FSM is locked, rises on other buttons are ignored. They are not queued; a still-held other button does not fire on return to IDLE.
- Long-press timing: first long event occurs between HOLD_TICKS-1 and HOLD_TICKS ticks after the press, because the tick phase is free-running.
- Emit:
  - registered; event_valid_out, id and long update at the clock edge following the cycle the condition is detected;
  - e.g. btn_in rises before edge k, so valid is high after edge k.
- Handshake:
  - valid, id and long hold stable until valid & ready;
  - valid drops the cycle after acceptance unless a new emit occurs at the same edge, in which case the new event loads directly.
- Emit while valid & !ready: the new event is dropped, the pending event is kept, and overrun_out <= 1. overrun_out clears only on reset.
- Counter widths: hold_cnt $clog2(HOLD_TICKS+1), rep_cnt $clog2(REPEAT_TICKS+1). No wrap occurs because both reset at their terminal value.
- busy_out = (state != IDLE), combinational from the state register.
- HOLD_TICKS and REPEAT_TICKS must be ≥ 1.

Optional Feature:
- Macro BTN_AUTOREPEAT_EN.
- Defined: REPEAT state as above; periodic long = 1 events while held.
- Undefined:
  - the HOLD_TICKS terminal emits exactly one long = 1 event and goes to LONG;
  - LONG waits for release (then IDLE) and emits nothing more;
  - rep_cnt and its logic are absent.

Test Plan:
- Bench parameters: TICK_DIV=4, HOLD_TICKS=3, REPEAT_TICKS=2, N_BTN=3, event_ready_in tied to 1.
- Reset: hold rst_n_in = 0 with btn_in = 3'b111. All outputs 0, tick_out silent. After release, tick_out pulses every 4 cycles and no event fires until a fresh rise.
- Short press: btn_in = 3'b010 for 5 cycles, then 0. Exactly one event with id = 1, long = 0, valid one cycle. busy_out high 5 cycles.
- Long press with repeat (macro defined): hold btn_in[0] for 40 cycles. Events observed:
  - long = 0 at press;
  - long = 1 on the 3rd tick;
  - long = 1 every 2 ticks after that;
  - none after release.
- Long press without the macro: same stimulus. Exactly two events (long = 0, then one long = 1), then busy_out stays high until release.
- Simultaneous / locked: btn_in 3'b000 → 3'b110 gives a single event with id = 1. Button 2 pulsing while 1 is held produces no event. Release and a tick in the same cycle give no event.
- Backpressure: event_ready_in = 0 during a held-press sequence. The first event stays pending with stable id/long, later emits are dropped, overrun_out = 1 until reset. Raising ready accepts exactly the first event.
